// File: rtl/ttl_74298_sync.sv
// ttl_74298_sync: 74298-style multiplexer with storage, clocked by a sampled TTL clock pin.
// Optional build macro TTL_SYNC_EDGE_FILTER_EN adds a two-sample glitch filter before edge detection.
module ttl_74298_sync #(
  parameter int                BLOCKS       = 4,
  parameter int                WIDTH_IN     = 2,
  parameter int                WIDTH_SELECT = $clog2(WIDTH_IN),
  parameter int                EDGE_FALLING = 1,
  parameter logic [BLOCKS-1:0] RESET_VALUE  = {BLOCKS{1'b0}}
) (
  input  logic                         Clk,
  input  logic                         RST,
  input  logic                         Cen,
  input  logic                         Clk_ttl,
  input  logic                         Enable_bar,
  input  logic [WIDTH_SELECT-1:0]      Select,
  input  logic [BLOCKS*WIDTH_IN-1:0]   A_2D,
  output logic [BLOCKS-1:0]            Y,
  output logic                         Edge_strobe
);

  // Reset level of the sampled pin is the active level, so a first edge needs an inactive sample.
  localparam logic C_PREV_RST = (EDGE_FALLING != 0) ? 1'b0 : 1'b1;

  logic              r_clk_prev;
  logic              r_strobe;
  logic [BLOCKS-1:0] r_y;
  logic [BLOCKS-1:0] w_y_next;
  logic [WIDTH_IN-1:0] w_ch;
  logic              w_edge;
  logic              w_act;
  logic              w_sel_ok;
  logic              w_prev_load;

`ifdef TTL_SYNC_EDGE_FILTER_EN
  logic              r_samp;
  logic              w_stable;

  // A level counts only once it is seen on two consecutive qualified samples.
  always_comb begin
    w_stable    = (Clk_ttl == r_samp);
    w_prev_load = Cen & w_stable;
  end
`else
  // Without the filter every qualified sample updates the remembered level.
  always_comb begin
    w_prev_load = Cen;
  end
`endif

  // Active-edge detection from the remembered level and the current pin value.
  always_comb begin
    if (EDGE_FALLING != 0) begin
      w_edge = r_clk_prev & ~Clk_ttl;
    end else begin
      w_edge = ~r_clk_prev & Clk_ttl;
    end
`ifdef TTL_SYNC_EDGE_FILTER_EN
    w_act = Cen & w_stable & w_edge;
`else
    w_act = Cen & w_edge;
`endif
  end

  // Per-channel selection; an out-of-range select leaves every channel at its stored value.
  always_comb begin
    w_sel_ok = (32'(Select) < 32'(WIDTH_IN));
    w_y_next = r_y;
    w_ch     = {WIDTH_IN{1'b0}};
    for (int i = 0; i < BLOCKS; i++) begin
      w_ch = A_2D[i*WIDTH_IN +: WIDTH_IN];
      if (w_sel_ok) begin
        w_y_next[i] = w_ch[Select];
      end else begin
        w_y_next[i] = r_y[i];
      end
    end
  end

  // Sampled pin history, output register and edge strobe.
  always_ff @(posedge Clk) begin
    if (RST) begin
      r_clk_prev <= C_PREV_RST;
      r_strobe   <= 1'b0;
      r_y        <= RESET_VALUE;
`ifdef TTL_SYNC_EDGE_FILTER_EN
      r_samp     <= C_PREV_RST;
`endif
    end else begin
      if (w_prev_load) begin
        r_clk_prev <= Clk_ttl;
      end
`ifdef TTL_SYNC_EDGE_FILTER_EN
      if (Cen) begin
        r_samp <= Clk_ttl;
      end
`endif
      r_strobe <= w_act;
      if (w_act && !Enable_bar) begin
        r_y <= w_y_next;
      end
    end
  end

  assign Y           = r_y;
  assign Edge_strobe = r_strobe;

endmodule

// File: tb/tb_ttl_74298_sync.sv
// Self-checking bench for ttl_74298_sync: three instances (falling/2-input, falling/3-input,
// rising/2-input) share control inputs and are compared against a level-history reference model.
module tb_ttl_74298_sync;

`ifdef TTL_SYNC_EDGE_FILTER_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 1;
`endif

  logic        clk;
  logic        rst;
  logic        cen;
  logic        clk_ttl;
  logic        en_bar;
  logic [7:0]  a2;
  logic        sel2;
  logic [11:0] a3;
  logic [1:0]  sel3;
  logic [3:0]  y0, y1, y2;
  logic        st0, st1, st2;

  logic [3:0]  y_dut [3];
  logic        st_dut [3];

  int n_checks = 0;
  int n_fail   = 0;

  bit         m_prev [3];
  bit         m_last [3];
  logic [3:0] exp_y  [3];
  bit         exp_st [3];

  ttl_74298_sync u_dut0 (
    .Clk(clk), .RST(rst), .Cen(cen), .Clk_ttl(clk_ttl), .Enable_bar(en_bar),
    .Select(sel2), .A_2D(a2), .Y(y0), .Edge_strobe(st0));

  ttl_74298_sync #(.WIDTH_IN(3)) u_dut1 (
    .Clk(clk), .RST(rst), .Cen(cen), .Clk_ttl(clk_ttl), .Enable_bar(en_bar),
    .Select(sel3), .A_2D(a3), .Y(y1), .Edge_strobe(st1));

  ttl_74298_sync #(.EDGE_FALLING(0), .RESET_VALUE(4'b0101)) u_dut2 (
    .Clk(clk), .RST(rst), .Cen(cen), .Clk_ttl(clk_ttl), .Enable_bar(en_bar),
    .Select(sel2), .A_2D(a2), .Y(y2), .Edge_strobe(st2));

  assign y_dut[0] = y0;
  assign y_dut[1] = y1;
  assign y_dut[2] = y2;
  assign st_dut[0] = st0;
  assign st_dut[1] = st1;
  assign st_dut[2] = st2;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit act_lvl(int k);
    return (k == 2);
  endfunction

  // Advance the reference model with the inputs of this cycle, then clock once.
  task automatic tick();
    bit          act;
    int          w;
    int          s;
    logic [11:0] a;
    for (int k = 0; k < 3; k++) begin
      w   = (k == 1) ? 3 : 2;
      a   = (k == 1) ? a3 : {4'b0000, a2};
      s   = (k == 1) ? int'(sel3) : int'(sel2);
      act = 1'b0;
      if (rst) begin
        m_prev[k] = act_lvl(k);
        m_last[k] = act_lvl(k);
        exp_y[k]  = (k == 2) ? 4'b0101 : 4'b0000;
        exp_st[k] = 1'b0;
      end else begin
        if (cen) begin
`ifdef TTL_SYNC_EDGE_FILTER_EN
          if (clk_ttl == m_last[k] && clk_ttl != m_prev[k]) begin
            act       = (clk_ttl == act_lvl(k));
            m_prev[k] = clk_ttl;
          end
          m_last[k] = clk_ttl;
`else
          act       = (clk_ttl != m_prev[k]) && (clk_ttl == act_lvl(k));
          m_prev[k] = clk_ttl;
`endif
        end
        exp_st[k] = act;
        if (act && !en_bar && s < w) begin
          for (int ch = 0; ch < 4; ch++) exp_y[k][ch] = a[ch*w + s];
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cen = 1'b1; clk_ttl = 1'b0; en_bar = 1'b0;
    a2 = 8'hFF; a3 = 12'hFFF; sel2 = 1'b1; sel3 = 2'd0;
    for (int n = 0; n < 2; n++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (y_dut[k] !== exp_y[k] || st_dut[k] !== exp_st[k]) begin
          n_fail++;
          $display("FAIL reset dut%0d: Y=%b strobe=%b, expected Y=%b strobe=%b", k, y_dut[k], st_dut[k], exp_y[k], exp_st[k]);
        end
      end
    end
    n_checks++;
    if (y0 !== 4'b0000 || st0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_value: Y=%b strobe=%b, expected Y=0000 strobe=0", y0, st0);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (y0 !== 4'b0000 || st0 !== 1'b0) begin
      n_fail++;
      $display("FAIL first_sample_after_reset: Y=%b strobe=%b, expected Y=0000 strobe=0", y0, st0);
    end
  endtask

  task automatic test_falling_capture();
    a2 = 8'b10_01_10_01; sel2 = 1'b1; en_bar = 1'b0; cen = 1'b1;
    a3 = 12'($urandom); sel3 = 2'($urandom_range(0, 2));
    clk_ttl = 1'b1;
    for (int n = 0; n < 2; n++) tick();
    clk_ttl = 1'b0;
    for (int n = 0; n < DLY + 1; n++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (y_dut[k] !== exp_y[k] || st_dut[k] !== exp_st[k]) begin
          n_fail++;
          $display("FAIL falling_capture dut%0d: Y=%b strobe=%b, expected Y=%b strobe=%b", k, y_dut[k], st_dut[k], exp_y[k], exp_st[k]);
        end
      end
      n_checks++;
      if (y0 !== ((n >= DLY - 1) ? 4'b1010 : 4'b0000) || st0 !== (n == DLY - 1)) begin
        n_fail++;
        $display("FAIL falling_capture_value step%0d: Y=%b strobe=%b", n, y0, st0);
      end
    end
  endtask

  task automatic test_hold_enable();
    int strobes;
    strobes = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (st0 === 1'b1) strobes++;
    end
    n_checks++;
    if (strobes != 0 || y0 !== 4'b1010) begin
      n_fail++;
      $display("FAIL hold_low: extra strobes=%0d Y=%b, expected 0 strobes Y=1010", strobes, y0);
    end
    a2 = 8'b01_10_01_10; en_bar = 1'b1;
    clk_ttl = 1'b1;
    for (int n = 0; n < 2; n++) tick();
    clk_ttl = 1'b0;
    for (int n = 0; n < DLY; n++) tick();
    n_checks++;
    if (y0 !== 4'b1010 || st0 !== 1'b1) begin
      n_fail++;
      $display("FAIL enable_bar_hold: Y=%b strobe=%b, expected Y=1010 strobe=1", y0, st0);
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (y_dut[k] !== exp_y[k] || st_dut[k] !== exp_st[k]) begin
        n_fail++;
        $display("FAIL enable_bar dut%0d: Y=%b strobe=%b, expected Y=%b strobe=%b", k, y_dut[k], st_dut[k], exp_y[k], exp_st[k]);
      end
    end
    en_bar = 1'b0;
  endtask

  task automatic test_cen_gating();
    cen = 1'b1; clk_ttl = 1'b1;
    for (int n = 0; n < 2; n++) tick();
    a2 = 8'($urandom); sel2 = 1'($urandom);
    cen = 1'b0;
    for (int n = 0; n < 3; n++) begin
      clk_ttl = (n == 1) ? 1'b0 : 1'b1;
      tick();
      n_checks++;
      if (st0 !== 1'b0 || st2 !== 1'b0) begin
        n_fail++;
        $display("FAIL cen_gated_strobe step%0d: strobe0=%b strobe2=%b, expected 0", n, st0, st2);
      end
    end
    cen = 1'b1; clk_ttl = 1'b0;
    for (int n = 0; n < DLY; n++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (y_dut[k] !== exp_y[k] || st_dut[k] !== exp_st[k]) begin
          n_fail++;
          $display("FAIL cen_gating dut%0d: Y=%b strobe=%b, expected Y=%b strobe=%b", k, y_dut[k], st_dut[k], exp_y[k], exp_st[k]);
        end
      end
    end
    n_checks++;
    if (st0 !== 1'b1) begin
      n_fail++;
      $display("FAIL cen_capture: strobe=%b, expected 1", st0);
    end
  endtask

  task automatic test_nonpow2_select();
    logic [3:0] want;
    logic [3:0] held;
    sel3 = 2'd2; a3 = 12'($urandom); en_bar = 1'b0; cen = 1'b1;
    for (int i = 0; i < 4; i++) want[i] = a3[i*3 + 2];
    clk_ttl = 1'b1;
    for (int n = 0; n < 2; n++) tick();
    clk_ttl = 1'b0;
    for (int n = 0; n < DLY; n++) tick();
    n_checks++;
    if (y1 !== want || st1 !== 1'b1) begin
      n_fail++;
      $display("FAIL select_2: Y=%b strobe=%b, expected Y=%b strobe=1", y1, st1, want);
    end
    held = y1;
    sel3 = 2'd3; a3 = ~a3;
    clk_ttl = 1'b1;
    for (int n = 0; n < 2; n++) tick();
    clk_ttl = 1'b0;
    for (int n = 0; n < DLY; n++) tick();
    n_checks++;
    if (y1 !== want || st1 !== 1'b1 || y1 !== held) begin
      n_fail++;
      $display("FAIL select_out_of_range: Y=%b strobe=%b, expected Y=%b strobe=1", y1, st1, want);
    end
  endtask

  task automatic test_glitch();
    int strobes;
    cen = 1'b1; en_bar = 1'b0;
    clk_ttl = 1'b1;
    for (int n = 0; n < 2; n++) tick();
    strobes = 0;
    clk_ttl = 1'b0; tick();
    if (st0 === 1'b1) strobes++;
    clk_ttl = 1'b1; tick();
    if (st0 === 1'b1) strobes++;
    n_checks++;
    if (strobes != ((DLY == 2) ? 0 : 1)) begin
      n_fail++;
      $display("FAIL one_sample_low: strobes=%0d, expected %0d", strobes, (DLY == 2) ? 0 : 1);
    end
    tick();
    clk_ttl = 1'b0;
    for (int n = 0; n < 2; n++) begin
      tick();
      n_checks++;
      if (st0 !== (n == DLY - 1)) begin
        n_fail++;
        $display("FAIL two_sample_low step%0d: strobe=%b, expected %b", n, st0, (n == DLY - 1));
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst     = ($urandom_range(0, 49) == 0);
      cen     = ($urandom_range(0, 3) != 0);
      en_bar  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) clk_ttl = ~clk_ttl;
      a2      = 8'($urandom);
      a3      = 12'($urandom);
      sel2    = 1'($urandom);
      sel3    = 2'($urandom_range(0, 3));
      tick();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (y_dut[k] !== exp_y[k] || st_dut[k] !== exp_st[k]) begin
          n_fail++;
          $display("FAIL random cycle%0d dut%0d: Y=%b strobe=%b, expected Y=%b strobe=%b", n, k, y_dut[k], st_dut[k], exp_y[k], exp_st[k]);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cen = 1'b0; clk_ttl = 1'b0; en_bar = 1'b0;
    a2 = 8'h00; a3 = 12'h000; sel2 = 1'b0; sel3 = 2'd0;
    test_reset();
    test_falling_capture();
    test_hold_enable();
    test_cen_gating();
    test_nonpow2_select();
    test_glitch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
